// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: stalls, flushes, forwarding, memory wait/timeout
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             dmem_req_m,
  input  logic             dmem_ack,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 2);

  state_t     state, state_nx;
  logic [7:0] wcnt, wcnt_nx;
  logic       load_use;

  assign load_use = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] dm,
                                         input logic wm, input logic [4:0] dw, input logic ww);
    if (wm && (dm == rs) && (rs != 5'd0))      return 2'b10;
    else if (ww && (dw == rs) && (rs != 5'd0)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (rst) begin
      fwd_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      fwd_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    en_w     = 1'b1;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    mem_err  = 1'b0;
    if (!rst) begin
      {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req_m && !dmem_ack) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
            state_nx = MEMWAIT;
            wcnt_nx  = 8'd0;
          end else if (pc_src_e) begin
            // A taken branch squashes the load-use victim anyway, so it wins.
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
          end
        end
        MEMWAIT: begin
          wcnt_nx = wcnt + 8'd1;
          if (dmem_ack) begin
            state_nx = RUN;
          end else if (wcnt == WAIT_LIMIT) begin
            // Give up on the access and let the M instruction drain forward.
            mem_err  = 1'b1;
            state_nx = RUN;
          end else begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_f)   stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_e) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic load_e, pc_src_e, reg_write_m, reg_write_w, dmem_req_m, dmem_ack;

  logic en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, mem_err;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [31:0] stall_cnt, flush_cnt;

  logic t_en_f, t_en_d, t_en_e, t_en_m, t_en_w, t_flush_d, t_flush_e, t_mem_err;
  logic [1:0] t_fwd_a_e, t_fwd_b_e;
  logic [31:0] t_stall_cnt, t_flush_cnt;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .load_e(load_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .dmem_req_m(dmem_req_m),
    .dmem_ack(dmem_ack), .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .load_e(load_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .dmem_req_m(dmem_req_m),
    .dmem_ack(dmem_ack), .en_f(t_en_f), .en_d(t_en_d), .en_e(t_en_e), .en_m(t_en_m),
    .en_w(t_en_w), .flush_d(t_flush_d), .flush_e(t_flush_e), .fwd_a_e(t_fwd_a_e),
    .fwd_b_e(t_fwd_b_e), .mem_err(t_mem_err), .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt)
  );

  wire [4:0] en  = {en_f, en_d, en_e, en_m, en_w};
  wire [4:0] en4 = {t_en_f, t_en_d, t_en_e, t_en_m, t_en_w};
  wire [1:0] fl  = {flush_d, flush_e};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    dmem_req_m = 0; dmem_ack = 0;
  endtask

  initial begin
    // Reset with hazard-looking inputs: everything must stay quiet.
    rst = 0;
    clear_inputs();
    reg_write_m = 1; rd_m = 3; rs1_e = 3; pc_src_e = 1;
    next_cycle();
    next_cycle();
    chk("rst_en", en, 5'b00000);
    chk("rst_flush", fl, 2'b00);
    chk("rst_fwd_a", fwd_a_e, 2'b00);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);

    rst = 1;
    clear_inputs();
    #1;
    chk("idle_en", en, 5'b11111);
    chk("idle_flush", fl, 2'b00);

    // Load-use stall for exactly one cycle.
    next_cycle();
    load_e = 1; rd_e = 5; rs1_d = 5;
    #1;
    chk("lu_en", en, 5'b00111);
    chk("lu_flush", fl, 2'b01);
    next_cycle();
    clear_inputs();
    #1;
    chk("lu_resume_en", en, 5'b11111);
    chk("lu_resume_flush", fl, 2'b00);

    // x0 never causes a stall or a forward.
    next_cycle();
    load_e = 1; rd_e = 0; rs2_d = 0; reg_write_m = 1; rd_m = 0; rs1_e = 0;
    #1;
    chk("x0_en", en, 5'b11111);
    chk("x0_fwd_a", fwd_a_e, 2'b00);

    // Forwarding priority M over W.
    next_cycle();
    clear_inputs();
    reg_write_m = 1; reg_write_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 7;
    #1;
    chk("fwd_a_m", fwd_a_e, 2'b10);
    chk("fwd_b_m", fwd_b_e, 2'b10);
    reg_write_m = 0;
    #1;
    chk("fwd_a_w", fwd_a_e, 2'b01);
    chk("fwd_b_w", fwd_b_e, 2'b01);
    rs2_e = 8;
    #1;
    chk("fwd_b_none", fwd_b_e, 2'b00);
    chk("fwd_a_still_w", fwd_a_e, 2'b01);

    // Branch alone, then branch together with load-use.
    next_cycle();
    clear_inputs();
    pc_src_e = 1;
    #1;
    chk("br_en", en, 5'b11111);
    chk("br_flush", fl, 2'b11);
    next_cycle();
    load_e = 1; rd_e = 5; rs2_d = 5; pc_src_e = 1;
    #1;
    chk("br_lu_en", en, 5'b11111);
    chk("br_lu_flush", fl, 2'b11);
    next_cycle();
    clear_inputs();
    #1;
    chk("cnt_stall_a", stall_cnt, PERF * 1);
    chk("cnt_flush_a", flush_cnt, PERF * 3);

    // Memory wait, ack three cycles after the request.
    rst = 0;
    next_cycle();
    rst = 1;
    dmem_req_m = 1;
    #1;
    chk("mw0_en", en, 5'b00000);
    chk("mw0_flush", fl, 2'b00);
    next_cycle();
    pc_src_e = 1; load_e = 1; rd_e = 5; rs1_d = 5;
    #1;
    chk("mw1_en", en, 5'b00000);
    chk("mw1_flush_override", fl, 2'b00);
    next_cycle();
    pc_src_e = 0; load_e = 0; rd_e = 0; rs1_d = 0;
    #1;
    chk("mw2_en", en, 5'b00000);
    next_cycle();
    dmem_ack = 1;
    #1;
    chk("mw_ack_en", en, 5'b11111);
    chk("mw_ack_mem_err", mem_err, 1'b0);
    chk("mw_ack_mem_err_t4", t_mem_err, 1'b0);
    chk("mw_stall_cnt", stall_cnt, PERF * 3);
    chk("mw_flush_cnt", flush_cnt, 0);
    next_cycle();
    clear_inputs();
    #1;
    chk("mw_after_en", en, 5'b11111);

    // Same-cycle ack does not stall.
    dmem_req_m = 1; dmem_ack = 1;
    #1;
    chk("same_ack_en", en, 5'b11111);
    next_cycle();
    clear_inputs();

    // Timeout on the MEM_TIMEOUT=4 instance.
    rst = 0;
    next_cycle();
    rst = 1;
    dmem_req_m = 1;
    #1;
    chk("to0_mem_err", t_mem_err, 1'b0);
    chk("to0_en", en4, 5'b00000);
    next_cycle();
    #1;
    chk("to1_mem_err", t_mem_err, 1'b0);
    next_cycle();
    #1;
    chk("to2_mem_err", t_mem_err, 1'b0);
    chk("to2_en", en4, 5'b00000);
    next_cycle();
    #1;
    chk("to3_mem_err", t_mem_err, 1'b1);
    chk("to3_en", en4, 5'b11111);
    chk("to3_mem_err_def", mem_err, 1'b0);
    next_cycle();
    dmem_req_m = 0;
    #1;
    chk("to4_mem_err", t_mem_err, 1'b0);
    chk("to4_en_run", en4, 5'b11111);
    chk("def_still_wait_en", en, 5'b00000);

    // Reset while the default instance is still waiting.
    next_cycle();
    rst = 0;
    #1;
    chk("rst_mw_en", en, 5'b00000);
    chk("rst_mw_mem_err", mem_err, 1'b0);
    next_cycle();
    rst = 1;
    #1;
    chk("post_rst_en", en, 5'b11111);
    chk("post_rst_stall_cnt", stall_cnt, 0);
    chk("post_rst_flush_cnt", flush_cnt, 0);
    chk("post_rst_mem_err", mem_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
